// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    localparam int unsigned LED_OFF   = 0;
    localparam int unsigned CYC_OFF   = 4;
    localparam int unsigned MIS_OFF   = 8;

    localparam int unsigned RAM_WORDS = 64;
    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Core load/store request bus: level request held by the initiator until ready.
interface dmem_wait_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] dataOut;
    logic              ready;

    modport master (output memRead, memWrite, addr, data, input dataOut, ready);
    modport slave  (input memRead, memWrite, addr, data, output dataOut, ready);
endinterface

// File: rtl/dmem_ram.sv
// 64-word RAM: synchronous write, registered read that holds until the next read.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // NOTE: storage arrays carry no reset; clearing them would forbid RAM inference.
    logic [DATA_W-1:0] mem_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory target: RAM plus LED / cycle / misalign MMIO registers,
// with ready held low for WAIT_CYCLES+1 cycles after a request is captured.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              DATA_W      = 32,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 8'hF0
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_wait_responder_if.slave  bus,
    output logic [7:0]            led,
    output logic [7:0]            misalignCnt
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-3:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          led_q, led_d;
    logic [7:0]          mis_q, mis_d;
    logic [31:0]         cyc_q;
    logic [DATA_W-1:0]   mmio_rd_q, mmio_rd_d;
    logic                src_ram_q, src_ram_d;

    logic                req;
    logic [ADDR_W-1:0]   word_addr;
    logic [ADDR_W-1:0]   off;
    logic                is_mmio;
    logic [DATA_W-1:0]   mmio_rdata;
    logic                ram_we, ram_re;
    logic [DATA_W-1:0]   ram_rdata;

    assign req       = bus.memRead | bus.memWrite;
    assign word_addr = {waddr_q, 2'b00};
    assign is_mmio   = (word_addr >= MMIO_BASE);
    assign off       = word_addr - MMIO_BASE;

    always_comb begin
        mmio_rdata = '0;
        case (off)
            ADDR_W'(LED_OFF): mmio_rdata = DATA_W'(led_q);
            ADDR_W'(CYC_OFF): mmio_rdata = DATA_W'(cyc_q);
            ADDR_W'(MIS_OFF): mmio_rdata = DATA_W'(mis_q);
            default:          mmio_rdata = '0;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        waddr_d   = waddr_q;
        data_d    = data_q;
        led_d     = led_q;
        mis_d     = mis_q;
        mmio_rd_d = mmio_rd_q;
        src_ram_d = src_ram_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                // Write wins when both request lines are high.
                write_d = bus.memWrite;
                waddr_d = bus.addr[ADDR_W-1:2];
                data_d  = bus.data;
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = WAIT;
                if (bus.addr[1:0] != 2'b00 && mis_q != 8'hFF) mis_d = mis_q + 8'd1;
            end
            WAIT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = DONE;
                if (write_q) begin
                    if (is_mmio) begin
                        if (off == ADDR_W'(LED_OFF)) led_d = data_q[7:0];
                        if (off == ADDR_W'(MIS_OFF)) mis_d = '0;
                    end else begin
                        ram_we = 1'b1;
                    end
                end else if (is_mmio) begin
                    mmio_rd_d = mmio_rdata;
                    src_ram_d = 1'b0;
                end else begin
                    ram_re    = 1'b1;
                    src_ram_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            led_q     <= '0;
            mis_q     <= '0;
            cyc_q     <= '0;
            mmio_rd_q <= '0;
            src_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            led_q     <= led_d;
            mis_q     <= mis_d;
            cyc_q     <= cyc_q + 32'd1;
            mmio_rd_q <= mmio_rd_d;
            src_ram_q <= src_ram_d;
        end
    end

    // RAM has no reset of its own, so an access abandoned by reset must not reach it.
    dmem_ram #(.DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we & ~rst),
        .re_i    (ram_re & ~rst),
        .addr_i  (waddr_q[RAM_AW-1:0]),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign bus.dataOut = src_ram_q ? ram_rdata : mmio_rd_q;
    assign bus.ready   = (state_q == DONE) | ((state_q == IDLE) & ~req);
    assign led         = led_q;
    assign misalignCnt = mis_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder with WAIT_CYCLES=2 (ready at t0+4).
module tb_dmem_wait_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led;
    logic [7:0] mis;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    dmem_wait_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_wait_responder #(
        .ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2), .MMIO_BASE(8'hF0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .led         (led),
        .misalignCnt (mis)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one request just after a rising edge, waits (bounded) for ready,
    // samples dataOut in the completion cycle and drops the request.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [7:0] a, input logic [31:0] d,
                             output logic [31:0] rdat, output int lat);
        logic done;
        bus.memRead  = rd;
        bus.memWrite = wr;
        bus.addr     = a;
        bus.data     = d;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            if (bus.ready) done = 1'b1;
            else lat++;
        end
        check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
        rdat = bus.dataOut;
        @(posedge clk);
        #1;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
    endtask

    logic [31:0] rdat, v1, v2;
    int          lat;

    initial begin
        rst          = 1'b1;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.addr     = '0;
        bus.data     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",   {31'd0, bus.ready}, 32'd1);
        check("rst_dataout", bus.dataOut, 32'h0);
        check("rst_led",     {24'd0, led}, 32'h0);
        check("rst_mis",     {24'd0, mis}, 32'h0);
        @(posedge clk);
        #1;

        // RAM write/read with latency check
        do_access("wr10", 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, rdat, lat);
        check("wr10_lat", lat, 32'd4);
        do_access("rd10", 1'b1, 1'b0, 8'h10, 32'h0, rdat, lat);
        check("rd10_lat",  lat, 32'd4);
        check("rd10_data", rdat, 32'hDEADBEEF);

        // LED register
        do_access("wrled", 1'b0, 1'b1, 8'hF0, 32'h000000A5, rdat, lat);
        @(negedge clk);
        check("led_val", {24'd0, led}, 32'hA5);
        @(posedge clk);
        #1;
        do_access("rdled", 1'b1, 1'b0, 8'hF0, 32'h0, rdat, lat);
        check("rdled_data", rdat, 32'h000000A5);

        // Cycle counter: second read starts exactly 10 cycles after the first
        do_access("cyc1", 1'b1, 1'b0, 8'hF4, 32'h0, v1, lat);
        repeat (5) @(posedge clk);
        #1;
        do_access("cyc2", 1'b1, 1'b0, 8'hF4, 32'h0, v2, lat);
        check("cyc_delta", v2 - v1, 32'd10);

        // Misaligned read and MISALIGN register
        do_access("rd13", 1'b1, 1'b0, 8'h13, 32'h0, rdat, lat);
        check("rd13_data", rdat, 32'hDEADBEEF);
        check("rd13_mis",  {24'd0, mis}, 32'd1);
        do_access("rdmis", 1'b1, 1'b0, 8'hF8, 32'h0, rdat, lat);
        check("rdmis_data", rdat, 32'h1);
        do_access("wrmis", 1'b0, 1'b1, 8'hF8, 32'h0, rdat, lat);
        check("wrmis_clr", {24'd0, mis}, 32'd0);
        // Misaligned write to MISALIGN: increment at capture, clear at completion
        do_access("wrmis9", 1'b0, 1'b1, 8'hF9, 32'h0, rdat, lat);
        check("wrmis9_clr", {24'd0, mis}, 32'd0);

        // Both request lines high: write only, dataOut keeps last read value (1)
        do_access("both20", 1'b1, 1'b1, 8'h20, 32'h12345678, rdat, lat);
        check("both20_hold", rdat, 32'h1);
        do_access("rd20", 1'b1, 1'b0, 8'h20, 32'h0, rdat, lat);
        check("rd20_data", rdat, 32'h12345678);

        // Writes to the read-only cycle counter are dropped, RAM untouched
        do_access("wrcyc", 1'b0, 1'b1, 8'hF4, 32'h0, rdat, lat);
        check("wrcyc_hold", rdat, 32'h12345678);

        // Reset abandons a pending write
        do_access("wr24", 1'b0, 1'b1, 8'h24, 32'hCAFEF00D, rdat, lat);
        do_access("rd27", 1'b1, 1'b0, 8'h27, 32'h0, rdat, lat);
        check("rd27_data", rdat, 32'hCAFEF00D);
        check("rd27_mis",  {24'd0, mis}, 32'd1);
        bus.memWrite = 1'b1;
        bus.addr     = 8'h24;
        bus.data     = 32'h00000055;
        @(negedge clk);
        check("abort_t0_ready", {31'd0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_wait_ready", {31'd0, bus.ready}, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.memWrite = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready",   {31'd0, bus.ready}, 32'd1);
        check("abort_led",     {24'd0, led}, 32'h0);
        check("abort_mis",     {24'd0, mis}, 32'h0);
        check("abort_dataout", bus.dataOut, 32'h0);
        @(posedge clk);
        #1;
        do_access("rd24", 1'b1, 1'b0, 8'h24, 32'h0, rdat, lat);
        check("rd24_old", rdat, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
Responder end of the core's data-memory request interface (memRead/memWrite/addr/data -> dataOut/ready), with configurable wait states.
- Serves a 64-word byte-addressed RAM plus a small MMIO window: LED register, free-running cycle counter, misalignment counter.
- Holds ready low while an access is pending; the core stalls on ready low.
- Sits beside the core as the target of its load/store path; a drop-in multi-cycle alternative to the single-cycle data memory.

Parameters:
ADDR_W, 8, byte address width.
DATA_W, 32, data word width.
WAIT_CYCLES, 2, extra cycles before an access completes (0 allowed).
MMIO_BASE, 8'hF0, first byte address of the MMIO window (window spans MMIO_BASE..8'hFF).

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
memRead  input  1  read request, level; held by the initiator until ready=1.
memWrite  input  1  write request, level; held until ready=1.
addr  input  ADDR_W  byte address; addr[7:2] selects the word.
data  input  DATA_W  write data.
dataOut  output  DATA_W  read data; valid in the completion cycle, held afterwards.
ready  output  1  completion/idle indicator (see Behaviour).
led  output  8  MMIO LED register.
misalignCnt  output  8  count of accesses with addr[1:0]!=0, saturating at 8'hFF.

Behaviour:
- Reset: state=IDLE, dataOut=0, led=0, misalignCnt=0, cycle counter=0, wait counter=0. RAM contents are not reset. A pending access is abandoned; no RAM or LED write occurs.
- req = memRead | memWrite.
- ready is combinational: ready = (state==DONE) | (state==IDLE & ~req). It is never 1 in WAIT.
- IDLE:
  - If req, capture op, addr, data and load cnt=WAIT_CYCLES, then go to WAIT.
  - Write has priority: if memRead and memWrite are both high, perform the write only; dataOut is unchanged.
- WAIT:
  - If cnt!=0, decrement cnt and stay in WAIT.
  - If cnt==0, perform the access on this edge and go to DONE.
- DONE: one cycle with ready=1. Unconditionally return to IDLE; the request is not re-sampled in DONE.
- Latency: request first seen at cycle t0 -> ready=1 at t0+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+3 cycles.
- Address decode (on the captured address):
  - addr >= MMIO_BASE:
    - MMIO_BASE+0 is LED: write sets led=data[7:0]; read returns {24'h0, led}.
    - MMIO_BASE+4 is CYCLES: read-only, 32-bit free-running counter incremented every non-reset cycle; wraps FFFFFFFF->0. Writes are ignored.
    - MMIO_BASE+8 is MISALIGN: read returns {24'h0, misalignCnt}; a write clears it to 0.
    - Other MMIO offsets: read 0, write ignored.
  - Otherwise the access goes to RAM word addr[7:2]. RAM words shadowed by the MMIO window are unreachable.
- Misalignment: addr[1:0] is ignored for data, and the access proceeds word-aligned. misalignCnt increments at capture time, saturating at 8'hFF.
  - Simultaneous misaligned access and MISALIGN write: the clear wins.
- dataOut updates only on read completion and holds its value otherwise, including across writes.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - MMIO offsets LED_OFF=0, CYC_OFF=4, MIS_OFF=8.
  - RAM_WORDS=64.
- Sub-module dmem_ram: 64x32 synchronous-write RAM with registered read, instantiated once. The responder issues the RAM read on the WAIT->DONE edge so its registered output is valid in DONE.

Test Plan:
- Reset, then idle with memRead=memWrite=0 -> ready=1, dataOut=0, led=0, misalignCnt=0.
- Write 32'hDEADBEEF to 8'h10 with WAIT_CYCLES=2, request held from t0 -> ready=0 at t0..t0+3, ready=1 at t0+4. Then read 8'h10 -> dataOut=32'hDEADBEEF in its completion cycle.
- Write 32'h000000A5 to 8'hF0 -> led=8'hA5 after completion. Read 8'hF4 twice, 10 cycles apart -> the second value exceeds the first by 10.
- Read 8'h13 (misaligned) -> returns word 4 contents, misalignCnt=1. Write 8'hF8 -> misalignCnt=0.
- memRead and memWrite both high, addr 8'h20, data 32'h12345678 -> RAM word 8 = 32'h12345678, dataOut unchanged from its prior value.
- Start a write of 32'h55 to 8'h24, assert rst during WAIT -> next cycle state=IDLE, ready=1 (request dropped). A later read of 8'h24 returns the old contents.
